// File: rtl/hazard_scoreboard.sv
// Load-use interlock for an in-order pipeline: tracks in-flight loads for MEM_LATENCY
// cycles and stalls any ID-stage reader of their destination until the data is forwardable.
module hazard_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_LATENCY    = 1,
  parameter int STALL_CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic                      id_rs1_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_is_load,
  input  logic                      ex_redirect,
  input  logic                      perf_clr,
  output logic                      pc_write,
  output logic                      IF_ID_write,
  output logic                      IF_ID_flush,
  output logic                      ctrl_sel,
  output logic                      hazard_stall,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [MEM_LATENCY-1:0]    vld_q, vld_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q [MEM_LATENCY];
  logic [REG_ADDR_WIDTH-1:0] rd_d [MEM_LATENCY];
  logic [STALL_CNT_W-1:0]    cnt_q, cnt_d;
  logic                      src1_hit, src2_hit, issue;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Each source is matched against every valid stage on its own, so x0/unused on one
  // side never masks a real dependency on the other.
  always_comb begin
    src1_hit = 1'b0;
    src2_hit = 1'b0;
    for (int k = 0; k < MEM_LATENCY; k++) begin
      if (vld_q[k] && (rd_q[k] == id_rs1)) src1_hit = 1'b1;
      if (vld_q[k] && (rd_q[k] == id_rs2)) src2_hit = 1'b1;
    end
    src1_hit = src1_hit & id_rs1_used & (id_rs1 != '0);
    src2_hit = src2_hit & id_rs2_used & (id_rs2 != '0);
  end

  assign hazard_stall = id_valid & (src1_hit | src2_hit) & ~ex_redirect;
  assign issue        = id_valid & id_is_load & (id_rd != '0) & ~hazard_stall & ~ex_redirect;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = issue;
    rd_d[0]  = id_rd;
    for (int k = 1; k < MEM_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
    cnt_d = cnt_q;
    if (perf_clr)          cnt_d = '0;
    else if (hazard_stall) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Destination addresses are qualified by vld_q, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < MEM_LATENCY; k++) rd_q[k] <= rd_d[k];
  end

  // Redirect outranks the interlock: the stalled instruction is on the wrong path anyway.
  always_comb begin
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    IF_ID_flush = 1'b0;
    ctrl_sel    = 1'b1;
    if (ex_redirect) begin
      IF_ID_flush = 1'b1;
      ctrl_sel    = 1'b0;
    end else if (hazard_stall) begin
      pc_write    = 1'b0;
      IF_ID_write = 1'b0;
      ctrl_sel    = 1'b0;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: three instances (latency 1, 3, 4) share one
// stimulus bus; each scenario checks the instance whose latency it targets.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_is_load = 1'b0, ex_redirect = 1'b0, perf_clr = 1'b0;

  logic a_pc, a_ifw, a_fl, a_cs, a_st; logic [3:0]  a_cnt;
  logic b_pc, b_ifw, b_fl, b_cs, b_st; logic [31:0] b_cnt;
  logic c_pc, c_ifw, c_fl, c_cs, c_st; logic [7:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_ADDR_WIDTH(5), .MEM_LATENCY(1), .STALL_CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .perf_clr(perf_clr), .pc_write(a_pc), .IF_ID_write(a_ifw),
    .IF_ID_flush(a_fl), .ctrl_sel(a_cs), .hazard_stall(a_st), .stall_cnt(a_cnt));

  hazard_scoreboard #(.REG_ADDR_WIDTH(5), .MEM_LATENCY(3), .STALL_CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .perf_clr(perf_clr), .pc_write(b_pc), .IF_ID_write(b_ifw),
    .IF_ID_flush(b_fl), .ctrl_sel(b_cs), .hazard_stall(b_st), .stall_cnt(b_cnt));

  hazard_scoreboard #(.REG_ADDR_WIDTH(5), .MEM_LATENCY(4), .STALL_CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .perf_clr(perf_clr), .pc_write(c_pc), .IF_ID_write(c_ifw),
    .IF_ID_flush(c_fl), .ctrl_sel(c_cs), .hazard_stall(c_st), .stall_cnt(c_cnt));

  // {pc_write, IF_ID_write, IF_ID_flush, ctrl_sel, hazard_stall}
  localparam logic [4:0] NORM = 5'b11010;
  localparam logic [4:0] STAL = 5'b00001;
  localparam logic [4:0] FLSH = 5'b11100;

  typedef struct {
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       rdr;
    logic       clr;
    logic [4:0] exp_ctl;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                              input logic ld, input logic rdr, input logic clr,
                              input logic [4:0] ec, input logic [3:0] en);
    vec_t t;
    t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2; t.rd = rd;
    t.ld = ld; t.rdr = rdr; t.clr = clr; t.exp_ctl = ec; t.exp_cnt = en;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                     input logic u2, input logic [4:0] rd, input logic ld, input logic rdr,
                     input logic clr);
    @(negedge clk);
    id_valid = v; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_rd = rd; id_is_load = ld; ex_redirect = rdr; perf_clr = clr;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    id_valid = 1'b0; id_is_load = 1'b0; ex_redirect = 1'b0; perf_clr = 1'b0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic first;

    //      v  rs1  u1 rs2  u2 rd    ld rdr clr ctl   cnt
    tbl[0]  = mk(0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 0, 0, NORM, 4'd0);
    tbl[1]  = mk(1, 5'd2, 1, 5'd0, 0, 5'd5,  1, 0, 0, NORM, 4'd0); // lw x5
    tbl[2]  = mk(1, 5'd5, 1, 5'd1, 1, 5'd6,  0, 0, 0, STAL, 4'd0); // add x6,x5,x1
    tbl[3]  = mk(1, 5'd5, 1, 5'd1, 1, 5'd6,  0, 0, 0, NORM, 4'd1);
    tbl[4]  = mk(1, 5'd2, 1, 5'd0, 0, 5'd0,  1, 0, 0, NORM, 4'd1); // lw x0
    tbl[5]  = mk(1, 5'd0, 1, 5'd0, 1, 5'd1,  0, 0, 0, NORM, 4'd1); // add x1,x0,x0
    tbl[6]  = mk(1, 5'd2, 1, 5'd9, 1, 5'd9,  0, 0, 0, NORM, 4'd1); // sw
    tbl[7]  = mk(1, 5'd9, 1, 5'd9, 1, 5'd10, 0, 0, 0, NORM, 4'd1);
    tbl[8]  = mk(1, 5'd2, 1, 5'd0, 0, 5'd3,  1, 0, 0, NORM, 4'd1); // lw x3
    tbl[9]  = mk(1, 5'd0, 1, 5'd3, 1, 5'd11, 0, 0, 0, STAL, 4'd1); // rs1=x0, rs2 hit
    tbl[10] = mk(1, 5'd0, 1, 5'd3, 1, 5'd11, 0, 0, 0, NORM, 4'd2);
    tbl[11] = mk(1, 5'd2, 1, 5'd0, 0, 5'd4,  1, 0, 0, NORM, 4'd2); // lw x4
    tbl[12] = mk(1, 5'd4, 1, 5'd0, 0, 5'd12, 0, 1, 0, FLSH, 4'd2); // redirect beats stall
    tbl[13] = mk(1, 5'd2, 1, 5'd0, 0, 5'd4,  1, 1, 0, FLSH, 4'd2); // flushed lw x4
    tbl[14] = mk(1, 5'd4, 1, 5'd0, 0, 5'd12, 0, 0, 0, NORM, 4'd2);
    tbl[15] = mk(1, 5'd2, 1, 5'd0, 0, 5'd7,  1, 0, 0, NORM, 4'd2); // lw x7
    tbl[16] = mk(0, 5'd7, 1, 5'd0, 0, 5'd13, 0, 0, 0, NORM, 4'd2); // bubble in ID
    tbl[17] = mk(1, 5'd2, 1, 5'd0, 0, 5'd8,  1, 0, 0, NORM, 4'd2); // lw x8
    tbl[18] = mk(1, 5'd8, 0, 5'd8, 0, 5'd14, 0, 0, 0, NORM, 4'd2); // sources unused
    tbl[19] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 0, 1, NORM, 4'd2);
    tbl[20] = mk(0, 5'd0, 0, 5'd0, 0, 5'd0,  0, 0, 0, NORM, 4'd0);

    #1;
    chk("reset_ctl", {a_pc, a_ifw, a_fl, a_cs, a_st}, NORM);
    chk("reset_cnt", a_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      drv(tbl[i].v, tbl[i].rs1, tbl[i].u1, tbl[i].rs2, tbl[i].u2, tbl[i].rd,
          tbl[i].ld, tbl[i].rdr, tbl[i].clr);
      chk($sformatf("vec%0d_ctl", i), {a_pc, a_ifw, a_fl, a_cs, a_st}, tbl[i].exp_ctl);
      chk($sformatf("vec%0d_cnt", i), a_cnt, tbl[i].exp_cnt);
    end

    // Latency 3, consumer right after the load: 3 stalls.
    do_reset();
    drv(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      drv(1, 5'd7, 1, 5'd0, 1, 5'd8, 0, 0, 0);
      if (b_st) n++;
    end
    chk("lat3_d0_stalls", n, 3);
    chk("lat3_d0_cnt", b_cnt, 3);

    // Latency 3, one instruction in between, rs2=x0: 2 stalls.
    do_reset();
    drv(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 0, 0);
    drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    n = 0;
    first = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv(1, 5'd7, 1, 5'd0, 1, 5'd8, 0, 0, 0);
      if (i == 0) first = b_st;
      if (b_st) n++;
    end
    chk("lat3_d1_first", first, 1);
    chk("lat3_d1_stalls", n, 2);
    chk("lat3_d1_ctl", {b_pc, b_ifw, b_fl, b_cs, b_st}, NORM);

    // Latency 3, two loads to x5 in flight: stall until the younger one retires.
    do_reset();
    drv(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0, 0);
    drv(1, 5'd5, 0, 5'd0, 0, 5'd5, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      drv(1, 5'd5, 1, 5'd1, 1, 5'd6, 0, 0, 0);
      if (b_st) n++;
    end
    chk("lat3_dup_stalls", n, 3);

    // Latency 4, reset asserted two cycles into a stall.
    do_reset();
    drv(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 0, 0);
    drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 0, 0, 0);
    chk("lat4_stall_start", c_st, 1);
    drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 0, 0, 0);
    drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 0, 0, 0);
    chk("lat4_cnt_before_rst", c_cnt, 2);
    rst_n = 1'b0;
    #1;
    chk("lat4_rst_ctl", {c_pc, c_ifw, c_fl, c_cs, c_st}, NORM);
    chk("lat4_rst_cnt", c_cnt, 0);
    drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 0, 0, 0);
    chk("lat4_after_rst_stall", c_st, 0);
    chk("lat4_after_rst_cnt", c_cnt, 0);

    // Latency 1, 4-bit counter: 20 stalls saturate at 15, then clear wins over a stall.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drv(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0, 0);
      drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 0, 0, 0);
    end
    idle();
    chk("sat_cnt", a_cnt, 15);
    drv(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 0, 0);
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 0, 0, 1);
    chk("clr_stall", a_st, 1);
    idle();
    chk("clr_cnt", a_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
